// File: rtl/sipo.sv
// Serial-in, parallel-out deserializer with an optional input delay pipe.
// Words align to a sync marker travelling with the MSB and are presented with a one-cycle valid strobe.
module sipo #(
    parameter int WIDTH      = 50,
    parameter int EXTRA_BITS = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sync,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             aligned,
    output logic             realign
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        HUNT,
        SHIFT
    } state_t;

    state_t state, state_n;
    logic   s, d;

    generate
        if (WIDTH < 1 || EXTRA_BITS < 0) begin : g_bad_param
            initial begin
                $display("sipo: illegal parameters WIDTH=%0d EXTRA_BITS=%0d", WIDTH, EXTRA_BITS);
                $finish;
            end
            assign s = 1'b0;
            assign d = 1'b0;
        end else if (EXTRA_BITS == 0) begin : g_no_pipe
            assign s = sync;
            assign d = data_in;
        end else begin : g_pipe
            (* altera_attribute = "-name AUTO_SHIFT_REGISTER_RECOGNITION OFF", shreg_extract = "no" *)
            logic [EXTRA_BITS-1:0] ps, pd;
            logic [EXTRA_BITS:0]   ps_cat, pd_cat;

            assign ps_cat = {ps, sync};
            assign pd_cat = {pd, data_in};

            // Only the sync lane is cleared; stale data bits are harmless without a marker.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ps <= '0;
                end else begin
                    ps <= ps_cat[EXTRA_BITS-1:0];
                end
                pd <= pd_cat[EXTRA_BITS-1:0];
            end

            assign s = ps[EXTRA_BITS-1];
            assign d = pd[EXTRA_BITS-1];
        end
    endgenerate

    (* altera_attribute = "-name AUTO_SHIFT_REGISTER_RECOGNITION OFF", shreg_extract = "no" *)
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] sh_n, data_out_n, sh_shift;
    logic [WIDTH:0]   sh_cat;
    logic [CW-1:0]    bitcnt, bitcnt_n;
    logic             valid_n, realign_n;
    logic             take, first, last;

    assign sh_cat   = {sh, d};
    assign sh_shift = sh_cat[WIDTH-1:0];

    always_comb begin
        state_n    = state;
        sh_n       = sh;
        bitcnt_n   = bitcnt;
        data_out_n = data_out;
        valid_n    = 1'b0;
        realign_n  = 1'b0;
        take       = 1'b0;
        first      = 1'b0;
        last       = 1'b0;

        case (state)
            HUNT: begin
                if (s) begin
                    state_n = SHIFT;
                    sh_n    = WIDTH'(d);
                    take    = 1'b1;
                    first   = 1'b1;
                    last    = (WIDTH == 1);
                end
            end
            SHIFT: begin
                take = 1'b1;
                if (s && bitcnt != '0) begin
                    // Marker mid-word: drop the partial word and restart on this bit.
                    sh_n      = WIDTH'(d);
                    realign_n = 1'b1;
                    first     = 1'b1;
                    last      = (WIDTH == 1);
                end else begin
                    sh_n = sh_shift;
                    last = (bitcnt == CW'(WIDTH - 1));
                end
            end
            default: state_n = HUNT;
        endcase

        if (take) begin
            if (last) begin
                data_out_n = sh_n;
                valid_n    = 1'b1;
                bitcnt_n   = '0;
            end else if (first) begin
                bitcnt_n = CW'(1);
            end else begin
                bitcnt_n = bitcnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HUNT;
            sh       <= '0;
            bitcnt   <= '0;
            data_out <= '0;
            valid    <= 1'b0;
            realign  <= 1'b0;
        end else begin
            state    <= state_n;
            sh       <= sh_n;
            bitcnt   <= bitcnt_n;
            data_out <= data_out_n;
            valid    <= valid_n;
            realign  <= realign_n;
        end
    end

    assign aligned = (state == SHIFT);

endmodule

// File: tb/tb_sipo.sv
// Self-checking bench for sipo: directed scenarios plus a randomized stream against a bit-queue model.
// Three instances cover WIDTH=8/EXTRA_BITS=2, WIDTH=1/EXTRA_BITS=0 and WIDTH=8/EXTRA_BITS=0.
module tb_sipo;
    localparam int W = 8;
    localparam int E = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       sync_a, din_a, valid_a, aligned_a, realign_a;
    logic [7:0] dout_a;
    logic       sync_b, din_b, valid_b, aligned_b, realign_b;
    logic [0:0] dout_b;
    logic       sync_c, din_c, valid_c, aligned_c, realign_c;
    logic [7:0] dout_c;

    sipo #(.WIDTH(8), .EXTRA_BITS(2)) u_a (
        .clk(clk), .rst(rst), .sync(sync_a), .data_in(din_a),
        .data_out(dout_a), .valid(valid_a), .aligned(aligned_a), .realign(realign_a));
    sipo #(.WIDTH(1), .EXTRA_BITS(0)) u_b (
        .clk(clk), .rst(rst), .sync(sync_b), .data_in(din_b),
        .data_out(dout_b), .valid(valid_b), .aligned(aligned_b), .realign(realign_b));
    sipo #(.WIDTH(8), .EXTRA_BITS(0)) u_c (
        .clk(clk), .rst(rst), .sync(sync_c), .data_in(din_c),
        .data_out(dout_c), .valid(valid_c), .aligned(aligned_c), .realign(realign_c));

    int total = 0;
    int bad   = 0;

    // Reference model for u_a: expected outputs indexed by edge number after reset.
    bit         exp_v  [0:2047];
    bit         exp_r  [0:2047];
    bit         exp_al [0:2047];
    logic [7:0] exp_d  [0:2047];
    int         k;
    bit         m_lock;
    bit         mq[$];
    logic [7:0] m_last;

    task automatic reset_all();
        rst    = 1'b1;
        sync_a = 1'($urandom); din_a = 1'($urandom);
        sync_b = 1'($urandom); din_b = 1'($urandom);
        sync_c = 1'($urandom); din_c = 1'($urandom);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        sync_a = 0; din_a = 0; sync_b = 0; din_b = 0; sync_c = 0; din_c = 0;
        m_lock = 0;
        mq.delete();
        m_last = 8'h00;
        k      = 0;
        for (int i = 0; i < E; i++) begin
            exp_v[i] = 0; exp_r[i] = 0; exp_al[i] = 0; exp_d[i] = 8'h00;
        end
    endtask

    task automatic step_a(input bit s, input bit b);
        bit         v, r;
        logic [7:0] w;
        v = 0;
        r = 0;
        if (m_lock && s && mq.size() != 0) begin
            r = 1;
            mq.delete();
        end
        if (s) m_lock = 1;
        if (m_lock) begin
            mq.push_back(b);
            if (mq.size() == W) begin
                w = 8'h00;
                foreach (mq[i]) w = {w[6:0], mq[i]};
                m_last = w;
                v = 1;
                mq.delete();
            end
        end
        exp_v[k+E] = v; exp_r[k+E] = r; exp_al[k+E] = m_lock; exp_d[k+E] = m_last;
        sync_a = s;
        din_a  = b;
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic test_reset();
        reset_all();
        total++;
        if (valid_a !== 0 || aligned_a !== 0 || realign_a !== 0 || dout_a !== 8'h00) begin
            bad++;
            $display("FAIL reset_a: v=%b al=%b r=%b d=%h want 0 0 0 00", valid_a, aligned_a, realign_a, dout_a);
        end
        total++;
        if (valid_b !== 0 || aligned_b !== 0 || realign_b !== 0 || dout_b !== 1'b0 ||
            valid_c !== 0 || aligned_c !== 0 || realign_c !== 0 || dout_c !== 8'h00) begin
            bad++;
            $display("FAIL reset_bc: b v=%b al=%b d=%h c v=%b al=%b d=%h want all 0",
                     valid_b, aligned_b, dout_b, valid_c, aligned_c, dout_c);
        end
    endtask

    task automatic run_words(input logic [7:0] w0, input logic [7:0] w1, input int nwords,
                             output int nvalid, output int e_first, output int e_second,
                             output int al_first, output logic [7:0] d0, output logic [7:0] d1);
        logic [7:0] w;
        nvalid = 0; e_first = -1; e_second = -1; al_first = -1; d0 = 'x; d1 = 'x;
        for (int i = 0; i < nwords * 8 + 6; i++) begin
            w = (i < 8) ? w0 : w1;
            if (i < nwords * 8) step_a(i == 0, w[7 - (i % 8)]);
            else step_a(0, 0);
            total++;
            if (valid_a !== exp_v[k-1] || realign_a !== exp_r[k-1] ||
                aligned_a !== exp_al[k-1] || dout_a !== exp_d[k-1]) begin
                bad++;
                $display("FAIL words e%0d: v=%b r=%b al=%b d=%h want %b %b %b %h", k-1,
                         valid_a, realign_a, aligned_a, dout_a,
                         exp_v[k-1], exp_r[k-1], exp_al[k-1], exp_d[k-1]);
            end
            if (aligned_a === 1'b1 && al_first < 0) al_first = k - 1;
            if (valid_a === 1'b1) begin
                nvalid++;
                if (e_first < 0) begin e_first = k - 1; d0 = dout_a; end
                else begin e_second = k - 1; d1 = dout_a; end
            end
        end
    endtask

    task automatic test_single_word();
        int n, e0, e1, al;
        logic [7:0] d0, d1;
        reset_all();
        run_words(8'hA5, 8'h00, 1, n, e0, e1, al, d0, d1);
        total++;
        if (n !== 1 || e0 !== 9 || d0 !== 8'hA5 || al !== 2) begin
            bad++;
            $display("FAIL single_word: pulses=%0d edge=%0d data=%h aligned_edge=%0d want 1 9 a5 2", n, e0, d0, al);
        end
    endtask

    task automatic test_back_to_back();
        int n, e0, e1, al;
        logic [7:0] d0, d1;
        reset_all();
        run_words(8'hA5, 8'h3C, 2, n, e0, e1, al, d0, d1);
        total++;
        if (n !== 2 || e0 !== 9 || e1 !== 17 || d0 !== 8'hA5 || d1 !== 8'h3C) begin
            bad++;
            $display("FAIL back_to_back: pulses=%0d edges=%0d,%0d data=%h,%h want 2 9,17 a5,3c", n, e0, e1, d0, d1);
        end
    endtask

    task automatic test_realign();
        logic [7:0] w = 8'hF0;
        int nv = 0, nr = 0, ev = -1, er = -1;
        logic [7:0] dv = 'x;
        reset_all();
        for (int i = 0; i < 3 + 8 + 5; i++) begin
            if (i < 3) step_a(i == 0, 1'b1);
            else if (i < 11) step_a(i == 3, w[7 - (i - 3)]);
            else step_a(0, 0);
            total++;
            if (valid_a !== exp_v[k-1] || realign_a !== exp_r[k-1] ||
                aligned_a !== exp_al[k-1] || dout_a !== exp_d[k-1]) begin
                bad++;
                $display("FAIL realign e%0d: v=%b r=%b al=%b d=%h want %b %b %b %h", k-1,
                         valid_a, realign_a, aligned_a, dout_a,
                         exp_v[k-1], exp_r[k-1], exp_al[k-1], exp_d[k-1]);
            end
            if (valid_a === 1'b1) begin nv++; ev = k - 1; dv = dout_a; end
            if (realign_a === 1'b1) begin nr++; er = k - 1; end
        end
        total++;
        if (nr !== 1 || er !== 5 || nv !== 1 || ev !== 12 || dv !== 8'hF0) begin
            bad++;
            $display("FAIL realign_summary: realigns=%0d@%0d valids=%0d@%0d data=%h want 1@5 1@12 f0",
                     nr, er, nv, ev, dv);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] w = 8'h96;
        int nv = 0, nal = 0;
        logic [7:0] dmax = 8'h00;
        reset_all();
        for (int i = 0; i < 5; i++) step_a(i == 0, w[7 - i]);
        reset_all();
        for (int i = 0; i < 20; i++) begin
            step_a(0, 1'($urandom));
            if (valid_a !== 1'b0) nv++;
            if (aligned_a !== 1'b0) nal++;
            dmax = dmax | dout_a;
        end
        total++;
        if (nv !== 0 || nal !== 0 || dmax !== 8'h00) begin
            bad++;
            $display("FAIL reset_mid: valid_cycles=%0d aligned_cycles=%0d data_or=%h want 0 0 00", nv, nal, dmax);
        end
    endtask

    task automatic test_random();
        int nv = 0, nr = 0;
        reset_all();
        for (int i = 0; i < 800; i++) begin
            step_a($urandom_range(0, 11) == 0, 1'($urandom));
            total++;
            if (valid_a !== exp_v[k-1] || realign_a !== exp_r[k-1] ||
                aligned_a !== exp_al[k-1] || dout_a !== exp_d[k-1]) begin
                bad++;
                $display("FAIL random e%0d: v=%b r=%b al=%b d=%h want %b %b %b %h", k-1,
                         valid_a, realign_a, aligned_a, dout_a,
                         exp_v[k-1], exp_r[k-1], exp_al[k-1], exp_d[k-1]);
            end
            nv += int'(exp_v[k-1]);
            nr += int'(exp_r[k-1]);
        end
        total++;
        if (nv == 0 || nr == 0) begin
            bad++;
            $display("FAIL random_coverage: model valids=%0d realigns=%0d want both nonzero", nv, nr);
        end
    endtask

    task automatic test_width1();
        logic [2:0] bits = 3'b101;
        reset_all();
        for (int i = 0; i < 3; i++) begin
            sync_b = (i == 0);
            din_b  = bits[2 - i];
            @(posedge clk);
            #1;
            total++;
            if (valid_b !== 1'b1 || dout_b !== bits[2 - i] || aligned_b !== 1'b1 || realign_b !== 1'b0) begin
                bad++;
                $display("FAIL width1 bit%0d: v=%b d=%b al=%b r=%b want 1 %b 1 0",
                         i, valid_b, dout_b, aligned_b, realign_b, bits[2 - i]);
            end
        end
        sync_b = 0;
        din_b  = 0;
    endtask

    task automatic test_loopback();
        logic [7:0] words [3];
        logic [7:0] got[$];
        int first_edge = -1;
        int bitpos;
        words[0] = 8'h5A; words[1] = 8'hC3; words[2] = 8'h01;
        reset_all();
        // Serializer loads every 8 cycles from cycle 0; its MSB reaches the pin two cycles later.
        for (int c = 0; c < 2 + 24 + 4; c++) begin
            bitpos = c - 2;
            if (bitpos >= 0 && bitpos < 24) begin
                sync_c = (bitpos % 8 == 0);
                din_c  = words[bitpos / 8][7 - (bitpos % 8)];
            end else begin
                sync_c = 0;
                din_c  = 0;
            end
            @(posedge clk);
            #1;
            if (valid_c === 1'b1) begin
                got.push_back(dout_c);
                if (first_edge < 0) first_edge = c;
            end
        end
        sync_c = 0;
        din_c  = 0;
        total++;
        if (got.size() !== 3 || first_edge !== 9) begin
            bad++;
            $display("FAIL loopback_count: words=%0d first_edge=%0d want 3 9", got.size(), first_edge);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= got.size() || got[i] !== words[i]) begin
                bad++;
                $display("FAIL loopback_word%0d: got=%h want %h", i,
                         (i < got.size()) ? got[i] : 8'hxx, words[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        sync_a = 0; din_a = 0; sync_b = 0; din_b = 0; sync_c = 0; din_c = 0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_realign();
        test_reset_mid();
        test_random();
        test_width1();
        test_loopback();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
